// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 sync generator: free-running counters with registered sync, blanking and coordinates.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.

module vga_sync_gen_chk #(
    parameter int CNT_W   = 10,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) ();
    if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_cnt_w_too_small
        $error("vga_sync_gen: CNT_W=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
               CNT_W, H_TOTAL - 1, V_TOTAL - 1);
    end
endmodule

module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0]      rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    vga_sync_gen_chk #(
        .CNT_W  (CNT_W),
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_chk ();

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    logic w_h_last;
    logic w_v_last;
    logic w_hsync_on;
    logic w_vsync_on;
    logic w_video_on;
    logic w_frame_start;

    assign w_h_last      = (r_h_cnt == H_LAST);
    assign w_v_last      = (r_v_cnt == V_LAST);
    assign w_hsync_on    = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
    assign w_vsync_on    = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
    assign w_video_on    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign w_frame_start = (r_h_cnt == {CNT_W{1'b0}}) && (r_v_cnt == {CNT_W{1'b0}});

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    function automatic logic [11:0] bar_color(input logic [CNT_W-1:0] idx);
        case (idx)
            CNT_W'(0): bar_color = 12'hFFF;
            CNT_W'(1): bar_color = 12'hFF0;
            CNT_W'(2): bar_color = 12'h0FF;
            CNT_W'(3): bar_color = 12'h0F0;
            CNT_W'(4): bar_color = 12'hF0F;
            CNT_W'(5): bar_color = 12'hF00;
            CNT_W'(6): bar_color = 12'h00F;
            default:   bar_color = 12'h000;
        endcase
    endfunction

    logic [CNT_W-1:0] w_bar_idx;
    logic [11:0]      w_rgb;

    assign w_bar_idx = r_h_cnt / CNT_W'(BAR_W);
    assign w_rgb     = w_video_on ? bar_color(w_bar_idx) : 12'h000;
`endif

    // Counters advance every pixel; outputs are a one-cycle-late registered decode of them.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_h_cnt     <= {CNT_W{1'b0}};
            r_v_cnt     <= {CNT_W{1'b0}};
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= {CNT_W{1'b0}};
            pixel_y     <= {CNT_W{1'b0}};
            frame_start <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            rgb         <= 12'h000;
`endif
        end else begin
            if (w_h_last) begin
                r_h_cnt <= {CNT_W{1'b0}};
                r_v_cnt <= w_v_last ? {CNT_W{1'b0}} : r_v_cnt + CNT_W'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CNT_W'(1);
            end
            hsync       <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
            video_on    <= w_video_on;
            pixel_x     <= r_h_cnt;
            pixel_y     <= r_v_cnt;
            frame_start <= w_frame_start;
`ifdef VGA_TEST_PATTERN_EN
            rgb         <= w_rgb;
`endif
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus a shrunken active-high-sync instance
// so whole frames fit in a short run; a per-cycle scoreboard backs the scenario checks.

module tb_vga_sync_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    always #20 clk_in = ~clk_in;

    logic       b_hs, b_vs, b_von, b_fs;
    logic [9:0] b_px, b_py;
    logic       s_hs, s_vs, s_von, s_fs;
    logic [9:0] s_px, s_py;
    logic [11:0] b_rgb_v, s_rgb_v;

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] b_rgb, s_rgb;
    assign b_rgb_v = b_rgb;
    assign s_rgb_v = s_rgb;
`else
    assign b_rgb_v = 12'h000;
    assign s_rgb_v = 12'h000;
`endif

    vga_sync_gen u_dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .hsync      (b_hs),
        .vsync      (b_vs),
        .video_on   (b_von),
        .pixel_x    (b_px),
        .pixel_y    (b_py),
        .frame_start(b_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .rgb        (b_rgb)
`endif
    );

    // Small timing: H_TOTAL=32, V_TOTAL=20, hsync 20..27, vsync lines 14..15, frame = 640 cycles.
    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(1'b1), .CNT_W(10)
    ) u_small (
        .clk_in     (clk_in),
        .reset      (reset),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .video_on   (s_von),
        .pixel_x    (s_px),
        .pixel_y    (s_py),
        .frame_start(s_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .rgb        (s_rgb)
`endif
    );

    exp_t q_big[$];
    exp_t q_small[$];
    int   bh = 0, bv = 0, sh = 0, sv = 0;
    int   kc = -1;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [11:0] bar(input int idx);
        case (idx)
            0:       bar = 12'hFFF;
            1:       bar = 12'hFF0;
            2:       bar = 12'h0FF;
            3:       bar = 12'h0F0;
            4:       bar = 12'hF0F;
            5:       bar = 12'hF00;
            6:       bar = 12'h00F;
            default: bar = 12'h000;
        endcase
    endfunction

    function automatic exp_t model(input int h, input int v, input int ha, input int hfp,
                                   input int hsy, input int va, input int vfp, input int vsy,
                                   input logic pol);
        exp_t m;
        m.hs  = (h >= ha + hfp && h < ha + hfp + hsy) ? pol : ~pol;
        m.vs  = (v >= va + vfp && v < va + vfp + vsy) ? pol : ~pol;
        m.von = (h < ha) && (v < va);
        m.px  = 10'(h);
        m.py  = 10'(v);
        m.fs  = (h == 0) && (v == 0);
        m.rgb = m.von ? bar(h / (ha / 8)) : 12'h000;
`ifndef VGA_TEST_PATTERN_EN
        m.rgb = 12'h000;
`endif
        return m;
    endfunction

    // Drive one cycle, push the expected outputs, then pop and score them after the edge.
    task automatic step(input logic rst);
        exp_t eb, es, ab, as_;
        reset = rst;
        if (rst) begin
            eb = '{hs: 1'b1, vs: 1'b1, von: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0, rgb: 12'h000};
            es = '{hs: 1'b0, vs: 1'b0, von: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0, rgb: 12'h000};
            bh = 0; bv = 0; sh = 0; sv = 0;
        end else begin
            eb = model(bh, bv, 640, 16, 96, 480, 10, 2, 1'b0);
            es = model(sh, sv, 16, 4, 8, 12, 2, 2, 1'b1);
            if (bh == 799) begin bh = 0; bv = (bv == 524) ? 0 : bv + 1; end else bh = bh + 1;
            if (sh == 31)  begin sh = 0; sv = (sv == 19)  ? 0 : sv + 1; end else sh = sh + 1;
        end
        q_big.push_back(eb);
        q_small.push_back(es);
        @(posedge clk_in);
        #1;
        kc  = rst ? -1 : kc + 1;
        ab  = {b_hs, b_vs, b_von, b_px, b_py, b_fs, b_rgb_v};
        as_ = {s_hs, s_vs, s_von, s_px, s_py, s_fs, s_rgb_v};
        eb  = q_big.pop_front();
        es  = q_small.pop_front();
        checks++;
        if (ab !== eb) begin
            errors++;
            if (errors <= 20) $display("FAIL sb_big k=%0d got %h expected %h", kc, ab, eb);
        end
        checks++;
        if (as_ !== es) begin
            errors++;
            if (errors <= 20) $display("FAIL sb_small k=%0d got %h expected %h", kc, as_, es);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            checks++;
            if ({b_hs, b_vs, b_von, b_px, b_py, b_fs} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_big cyc=%0d got hs=%b vs=%b von=%b x=%0d y=%0d fs=%b", i,
                         b_hs, b_vs, b_von, b_px, b_py, b_fs);
            end
            checks++;
            if ({s_hs, s_vs, s_von, s_fs} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_small cyc=%0d got hs=%b vs=%b von=%b fs=%b expected 0000", i,
                         s_hs, s_vs, s_von, s_fs);
            end
        end
    endtask

    task automatic test_line();
        int hs_low = 0, first_hs = -1, von_hi = 0;
        for (int i = 0; i <= 800; i++) begin
            step(1'b0);
            if (kc == 0) begin
                checks++;
                if ({b_fs, b_von, b_px} !== {1'b1, 1'b1, 10'd0}) begin
                    errors++;
                    $display("FAIL line_start got fs=%b von=%b x=%0d expected 1 1 0", b_fs, b_von, b_px);
                end
            end
            if (kc < 800) begin
                if (b_hs === 1'b0) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = kc;
                end
                if (b_von === 1'b1) von_hi++;
            end
            if (kc == 800) begin
                checks++;
                if ({b_px, b_py, b_fs, b_von} !== {10'd0, 10'd1, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL line_wrap got x=%0d y=%0d fs=%b von=%b expected 0 1 0 1",
                             b_px, b_py, b_fs, b_von);
                end
            end
        end
        checks++;
        if (hs_low !== 96 || first_hs !== 656) begin
            errors++;
            $display("FAIL hsync_pulse got width=%0d start=%0d expected 96 656", hs_low, first_hs);
        end
        checks++;
        if (von_hi !== 640) begin
            errors++;
            $display("FAIL video_on_width got %0d expected 640", von_hi);
        end
    endtask

    task automatic test_small_frame();
        int vs_hi = 0, first_vs = -1, fs_cnt = 0, fs_at = -1, max_y = 0, big_fs = 0;
        while (kc < 1300) begin
            step(1'b0);
            if (s_vs === 1'b1) begin
                vs_hi++;
                if (first_vs < 0) first_vs = kc;
            end
            if (s_fs === 1'b1) begin fs_cnt++; fs_at = kc; end
            if (int'(s_py) > max_y) max_y = int'(s_py);
            if (b_fs === 1'b1) big_fs++;
        end
        checks++;
        if (vs_hi !== 64 || first_vs !== 1088) begin
            errors++;
            $display("FAIL vsync_pulse got width=%0d start=%0d expected 64 1088", vs_hi, first_vs);
        end
        checks++;
        if (fs_cnt !== 1 || fs_at !== 1280) begin
            errors++;
            $display("FAIL frame_start_small got count=%0d at=%0d expected 1 1280", fs_cnt, fs_at);
        end
        checks++;
        if (max_y !== 19) begin
            errors++;
            $display("FAIL pixel_y_peak got %0d expected 19", max_y);
        end
        checks++;
        if (big_fs !== 0) begin
            errors++;
            $display("FAIL frame_start_big_spurious got %0d pulses expected 0", big_fs);
        end
    endtask

    task automatic test_mid_reset();
        while (kc < 1400) step(1'b0);
        step(1'b1);
        checks++;
        if ({b_hs, b_vs, b_von, b_px, b_py, b_fs, s_hs, s_vs, s_px, s_py} !==
            {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL mid_reset got hs=%b vs=%b von=%b x=%0d y=%0d fs=%b", b_hs, b_vs, b_von,
                     b_px, b_py, b_fs);
        end
        step(1'b0);
        checks++;
        if ({b_fs, b_px, b_py, s_fs, s_px, s_py} !== {1'b1, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL restart got fs=%b x=%0d y=%0d small_fs=%b expected 1 0 0 1",
                     b_fs, b_px, b_py, s_fs);
        end
    endtask

    task automatic test_pattern();
`ifdef VGA_TEST_PATTERN_EN
        int          bk[8] = '{0, 79, 80, 159, 560, 639, 640, 799};
        logic [11:0] bc[8] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h000, 12'h000, 12'h000, 12'h000};
        int          sk[5] = '{640, 641, 642, 655, 660};
        logic [11:0] sc[5] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h000, 12'h000};
        while (kc < 800) begin
            step(1'b0);
            for (int j = 0; j < 8; j++) begin
                if (kc == bk[j]) begin
                    checks++;
                    if (b_rgb !== bc[j]) begin
                        errors++;
                        $display("FAIL rgb_big x=%0d got %h expected %h", kc, b_rgb, bc[j]);
                    end
                end
            end
            for (int j = 0; j < 5; j++) begin
                if (kc == sk[j]) begin
                    checks++;
                    if (s_rgb !== sc[j]) begin
                        errors++;
                        $display("FAIL rgb_small k=%0d got %h expected %h", kc, s_rgb, sc[j]);
                    end
                end
            end
            if (kc >= 384 && kc < 416) begin
                checks++;
                if (s_rgb !== 12'h000) begin
                    errors++;
                    $display("FAIL rgb_blank_line k=%0d got %h expected 000", kc, s_rgb);
                end
            end
        end
`else
        while (kc < 800) step(1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_line();
        test_small_frame();
        test_mid_reset();
        test_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 timing from the 25 MHz pixel clock produced by the clock divider stage; directly downstream of it.
- Free-running horizontal and vertical counters drive registered hsync, vsync, video_on, pixel coordinates and a frame-start strobe.
- Pixel renderers and the DAC/pin stage consume these outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- CNT_W, 10, width of counters and coordinate outputs

Ports:
- clk_in  in  1  pixel clock (25 MHz from divider)
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  high inside visible area
- pixel_x  out  CNT_W  horizontal position (0..H_TOTAL-1)
- pixel_y  out  CNT_W  vertical position (0..V_TOTAL-1)
- frame_start  out  1  one-cycle pulse at position (0,0)
- rgb  out  12  {R4,G4,B4} test pattern; present only with VGA_TEST_PATTERN_EN

Behaviour:
- One clock (clk_in); reset is synchronous and active-high, sampled on posedge clk_in only.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal h_cnt, v_cnt reset to 0. h_cnt increments each cycle and wraps at H_TOTAL-1 to 0. v_cnt increments only on the h_cnt wrap, and wraps at V_TOTAL-1 to 0 when h_cnt also wraps.
- All outputs are registered decodes of the current (h_cnt, v_cnt), so outputs lag the counters by 1 cycle.
- Output cycle k (k = 0 at the first posedge with reset low) reflects counter position k mod 420000.
- Decodes:
  - hsync asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the full line width.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - pixel_x = h_cnt and pixel_y = v_cnt, always, including blanking.
  - frame_start = (h_cnt==0 && v_cnt==0).
- Reset values of outputs (hold for the whole time reset is high):
  - hsync = vsync = ~SYNC_POL (deasserted)
  - video_on = 0, pixel_x = 0, pixel_y = 0, frame_start = 0, rgb = 0
- Reset asserted mid-frame: counters and outputs return to reset values on that edge; timing restarts from (0,0) on the first edge with reset low. No partial sync pulses persist.
- Counter arithmetic is CNT_W bits unsigned. CNT_W must hold H_TOTAL-1 and V_TOTAL-1; the implementation checks this with an elaboration-time assertion.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- Defined: rgb port exists and is registered alongside the other outputs, with the same 1-cycle lag. In the active area it shows 8 vertical colour bars, each H_ACTIVE/8 = 80 px wide, selected by h_cnt/80: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. Outside the active area rgb = 000.
- Undefined: rgb port and all pattern logic are absent; the other outputs are unchanged.

Test Plan:
- Hold reset high 5 cycles -> hsync=vsync=1, video_on=0, pixel_x=pixel_y=0, frame_start=0 on every cycle.
- Release reset, run 1 line -> output cycle 0: frame_start=1, video_on=1, pixel_x=0. video_on falls at cycle 640. hsync=0 for cycles 656..751 (exactly 96). Line repeats at cycle 800 with pixel_y=1.
- Run 1 full frame -> vsync=0 for exactly 1600 consecutive cycles starting at cycle 490*800=392000. frame_start pulses again at cycle 420000 and never in between. pixel_y peaks at 524.
- Assert reset 1 cycle at output cycle ~200000 (mid-frame) -> outputs at reset values on that cycle; next cycle frame_start=1, pixel_x=pixel_y=0.
- SYNC_POL=1 build -> hsync/vsync pulses are high, with identical positions and widths.
- With VGA_TEST_PATTERN_EN: line 0 -> rgb=FFF at pixel_x 0..79, FF0 at 80..159, 000 at 560..639, 000 at 640..799. On line 480 -> rgb=000 throughout.
